ex_mdu_stage: RTL and testbench

Execute-stage multiply/divide unit, the parametrised successor to the single-cycle EX ALU path. It sits beside the ALU in EX, takes the same forwarded rs/rt operands, and runs multi-cycle MULT/MULTU/DIV/DIVU operations into architectural HI/LO registers. It also serves MTHI/MTLO/MFHI/MFLO and produces the stall request the hazard unit uses to hold later HI/LO users.

---
 rtl/ex_mdu_stage_pkg.sv | 39 +++
 rtl/e_mdu_core.sv | 78 +++++++
 rtl/ex_mdu_stage.sv | 129 ++++++++++++
 tb/tb_ex_mdu_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_stage_pkg.sv
// Shared op codes, FSM states and default latencies for the EX-stage multiply/divide unit.
// The accumulate codes are decoded only when MDU_MADD_EN is defined.
package ex_mdu_stage_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational product / quotient / remainder generator on latched operands.
// o_wr=0 flags a divide by zero so HI/LO keep their values; MDU_MADD_EN adds the {HI,LO} accumulator.
module e_mdu_core
  import ex_mdu_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
`ifdef MDU_MADD_EN
  input  logic [2*WIDTH-1:0] i_acc,
`endif
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic               o_wr
);

  logic               w_sgn_mul;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
  logic               w_sgn_div, w_a_neg, w_b_neg, w_div0;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;

  always_comb begin
    w_sgn_mul = (i_op == MD_MULT);
`ifdef MDU_MADD_EN
    w_sgn_mul = w_sgn_mul | (i_op == MD_MADD) | (i_op == MD_MSUB);
`endif
  end

  // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
  assign w_a_ext = w_sgn_mul ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = w_sgn_mul ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_sgn_div = (i_op == MD_DIV);
  assign w_a_neg   = w_sgn_div & i_a[WIDTH-1];
  assign w_b_neg   = w_sgn_div & i_b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -i_a : i_a;
  assign w_b_mag   = w_b_neg ? -i_b : i_b;
  assign w_div0    = (i_b == '0);
  assign w_q_mag   = w_a_mag / w_b_mag;
  assign w_r_mag   = w_a_mag % w_b_mag;
  // MIN_INT / -1 falls out as quotient MIN_INT, remainder 0 through the magnitude path.
  assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem     = w_a_neg ? -w_r_mag : w_r_mag;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    o_wr = 1'b0;
    case (i_op)
      MD_MULT, MD_MULTU: begin
        {o_hi, o_lo} = w_prod;
        o_wr         = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        if (!w_div0) begin
          o_hi = w_rem;
          o_lo = w_quo;
          o_wr = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: begin
        {o_hi, o_lo} = i_acc + w_prod;
        o_wr         = 1'b1;
      end
      MD_MSUB, MD_MSUBU: begin
        {o_hi, o_lo} = i_acc - w_prod;
        o_wr         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// EX-stage multi-cycle MULT/DIV unit with HI/LO, MTHI/MTLO/MFHI/MFLO and HI/LO hazard stall; busy N cycles after start.
// Ops presented while busy are ignored; MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] fwd_rs,
  input  logic [WIDTH-1:0] fwd_rt,
  input  logic [3:0]       md_op,
  input  logic             d_is_md,
  output logic             busy,
  output logic             start,
  output logic             stall_md,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0] w_core_hi, w_core_lo;
  logic             w_core_wr, w_is_mul, w_is_div, w_commit;

  always_comb begin
    w_is_mul = is_mul_op(md_op);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul | is_acc_op(md_op);
`endif
    w_is_div = is_div_op(md_op);
  end

  always_comb begin
    start       = 1'b0;
    w_commit    = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul || w_is_div) begin
          start       = 1'b1;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        if (r_cnt <= CW'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= MD_NONE;
      r_a  <= '0;
      r_b  <= '0;
    end else if (start) begin
      r_op <= md_op;
      r_a  <= fwd_rs;
      r_b  <= fwd_rt;
    end
  end

  e_mdu_core #(.WIDTH(WIDTH)) u_core (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
`ifdef MDU_MADD_EN
    .i_acc ({r_hi, r_lo}),
`endif
    .o_hi  (w_core_hi),
    .o_lo  (w_core_lo),
    .o_wr  (w_core_wr)
  );

  // MTHI/MTLO only land in IDLE, so they never race a commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit && w_core_wr) begin
      r_hi <= w_core_hi;
      r_lo <= w_core_lo;
    end else if (r_state == ST_IDLE) begin
      if (md_op == MD_MTHI) r_hi <= fwd_rs;
      if (md_op == MD_MTLO) r_lo <= fwd_rs;
    end
  end

  always_comb begin
    case (md_op)
      MD_MFHI: md_rdata = r_hi;
      MD_MFLO: md_rdata = r_lo;
      default: md_rdata = '0;
    endcase
  end

  assign busy     = (r_state == ST_RUN);
  assign stall_md = d_is_md & (start | busy);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Scoreboard bench for ex_mdu_stage: stimulus pushes expected {HI,LO}, a monitor checks on each busy fall.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fwd_rs, fwd_rt;
  logic [3:0]  md_op;
  logic        d_is_md;
  logic        busy, start, stall_md;
  logic [31:0] hi, lo, md_rdata;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  ex_mdu_stage #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .fwd_rs   (fwd_rs),
    .fwd_rt   (fwd_rt),
    .md_op    (md_op),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .start    (start),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: a busy 1->0 transition outside reset is a completed operation.
  initial begin
    logic        pb;
    logic [63:0] e;
    string       nm;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && pb && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {hi, lo}, 64'hx);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk(nm, {hi, lo}, e);
        end
      end
      pb = busy & reset_n;
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int n, input logic poke, input string nm);
    int busy_n, stall_n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    md_op = op; fwd_rs = a; fwd_rt = b; d_is_md = 1'b1;
    @(negedge clk);
    chk({nm, "_start"}, 64'(start), 64'd1);
    stall_n = int'(stall_md);
    @(posedge clk); #1;
    md_op  = poke ? MD_MTHI : MD_NONE;
    fwd_rs = 32'hDEAD_BEEF;
    fwd_rt = 32'h0000_0001;
    busy_n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
      stall_n += int'(stall_md);
      @(posedge clk); #1;
      md_op  = MD_NONE;
      fwd_rs = ~fwd_rs;
    end
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(n));
    chk({nm, "_stall_cycles"}, 64'(stall_n), 64'(n + 1));
    chk({nm, "_stall_after"}, 64'(stall_md), 64'd0);
    d_is_md = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v, input logic [63:0] exp, input string nm);
    @(posedge clk); #1;
    md_op = op; fwd_rs = v; d_is_md = 1'b0;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(negedge clk);
    chk(nm, {hi, lo}, exp);
  endtask

  task automatic mf(input logic [3:0] op, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    md_op = op;
    @(negedge clk);
    chk(nm, 64'(md_rdata), 64'(exp));
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; fwd_rs = '0; fwd_rt = '0; md_op = MD_MFHI; d_is_md = 1'b1;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_stall", 64'(stall_md), 64'd0);
    chk("rst_rdata", 64'(md_rdata), 64'd0);
    md_op = MD_NONE; d_is_md = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 1'b0, "mult_neg2x3");
    mf(MD_MFLO, 32'hFFFF_FFFA, "mflo_after_mult");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b0, "multu_max");
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b1, "div_neg7by2");
    mf(MD_MFHI, 32'hFFFF_FFFF, "mfhi_after_div");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0, "div_minint");
    mt(MD_MTHI, 32'h0000_1234, 64'h0000_1234_8000_0000, "mthi_1234");
    run_op(MD_DIVU, 32'd77, 32'd0, 64'h0000_1234_8000_0000, 10, 1'b0, "divu_by_zero");

    // Reset in the third busy cycle of a divide.
    @(posedge clk); #1;
    md_op = MD_DIV; fwd_rs = 32'd100; fwd_rt = 32'd7;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, 1'b0, "divu_after_reset");

    mt(MD_MTHI, 32'h0, 64'h0000_0000_0000_000E, "mthi_zero");
    mt(MD_MTLO, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "mtlo_ones");
`ifdef MDU_MADD_EN
    run_op(MD_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 1'b0, "maddu_carry");
`else
    @(posedge clk); #1;
    md_op = MD_MADDU; fwd_rs = 32'd1; fwd_rt = 32'd1;
    @(negedge clk);
    chk("maddu_off_start", 64'(start), 64'd0);
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(negedge clk);
    chk("maddu_off_busy", 64'(busy), 64'd0);
    chk("maddu_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
